keypad_emulator: RTL
====================

# keypad_emulator

Drives the column side of the 4x4 keypad matrix in response to the row strobes from the keypad scanner, so that key codes can be injected from logic (self-test, UART bridge, bench stimulus) instead of a physical keypad. Accepts 4-bit key codes over a valid/ready handshake, queues them, and plays each as a timed press followed by a release gap. The row/column mapping is the exact inverse of the scanner's decode, so the scanner's `keypadBuf` reports the injected code.

## Interface
- `HOLD_CYCLES`, 16: clock cycles a key stays pressed; must be >= 4 so every row phase of the scanner is covered.
- `GAP_CYCLES`, 16: release cycles after each press, with all columns high; must be >= 1.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `keypadRow`  input  4  active-low row strobe driven by the scanner.
- `keypadCol`  output  4  active-low column return to the scanner.
- `key_valid`  input  1  `key_code` is offered.
- `key_code`  input  4  key to inject, 0x0–0xF.
- `key_ready`  output  1  queue can accept a code this cycle.
- `busy`  output  1  a press or gap is in progress, or the queue is not empty.
- `fifo_count`  output  3  number of queued codes, not counting the key being played.

## Operation
- Code to (row, col) map; both are active-low:
  - 7 (1110,1110); 4 (1110,1101); 1 (1110,1011); 0 (1110,0111).
  - 8 (1101,1110); 5 (1101,1101); 2 (1101,1011); A (1101,0111).
  - 9 (1011,1110); 6 (1011,1101); 3 (1011,1011); B (1011,0111).
  - C/D/E/F (0111, 1110/1101/1011/0111).
- `keypadCol` is combinational from `keypadRow` and the registered current key:
  - in PRESS, when `keypadRow` equals the current key's row, `keypadCol` is that key's column pattern;
  - otherwise `keypadCol` = 4'b1111;
  - a `keypadRow` value that is not exactly one low bit gives 4'b1111.
- Queue: 4-entry FIFO.
  - Push on `key_valid && key_ready`.
  - `key_ready` = !full.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Codes are played in arrival order.
- FSM:
  - IDLE: if the queue is not empty, pop into `cur_key`, load the counter with HOLD_CYCLES-1, go to PRESS.
  - PRESS: decrement the counter; at 0, load GAP_CYCLES-1 and go to GAP.
  - GAP: decrement the counter; at 0, go to IDLE.
- `busy` = (state != IDLE) || (fifo_count != 0).
- Reset, async, at any time including mid-press:
  - state IDLE, FIFO emptied, counter 0, `cur_key` 0;
  - `keypadCol` = 4'b1111 immediately;
  - `key_ready` = 1, `busy` = 0, `fifo_count` = 0.

## Timing
- Code accepted at edge N:
  - `fifo_count` increments after N;
  - pop and entry into PRESS occur at N+1, if IDLE;
  - the column can be asserted from N+1 for exactly HOLD_CYCLES cycles.
- After PRESS: GAP lasts GAP_CYCLES cycles, then at least 1 IDLE cycle.
- Back-to-back key period = HOLD_CYCLES + GAP_CYCLES + 1 cycles.
- `key_ready` deasserts in the cycle after the 4th queued push. It reasserts in the cycle after a pop from a full queue.
- `keypadCol` follows `keypadRow` combinationally with no register stage. This holds the scanner's same-edge sample of {row, col}.

## Configuration
- `KEYPAD_EMU_FIFO_EN` defined: 4-entry FIFO as above; `fifo_count` ranges 0–4.
- Not defined: the queue is a single holding register.
  - `key_ready` = 1 only when the register is empty.
  - `fifo_count` ranges 0–1.
  - All FSM and timing behaviour is otherwise identical.

## Test plan
- Reset release with no push (run with the scanner) -> `keypadCol` = 1111 for all row strobes; `key_ready` = 1; `busy` = 0; scanner `keypadBuf` stays 0.
- Push 0x5 (HOLD 16, GAP 16) -> `keypadCol` = 1101 exactly when `keypadRow` = 1101, for 16 cycles starting one edge after accept; scanner `keypadBuf` = 5; `busy` falls 33 cycles after accept.
- Push 0x7, 0x0, 0xA, 0xF back-to-back -> `fifo_count` sequence 1,2,3 then holds as pops interleave; `keypadBuf` steps 7, 0, A, F in order; press starts 33 cycles apart.
- Push 5 codes while the first is playing (FIFO_EN) -> `key_ready` low when `fifo_count` = 4; the 5th is held off until the next pop; no code is lost or duplicated.
- Assert `rst` mid-PRESS of 0xC -> `keypadCol` = 1111 in the same cycle; `fifo_count` = 0; after release nothing is replayed.
- Drive `keypadRow` = 1100 and 1111 during a PRESS of 0x8 -> `keypadCol` = 1111 for both.

Source files
------------

// File: rtl/keypad_emulator_if.sv
// Key-code injection handshake between a code source and keypad_emulator.
interface keypad_emulator_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;

    modport master (output key_valid, output key_code, input key_ready);
    modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_emulator.sv
// Keypad column emulator: queues injected key codes and answers scanner row strobes as a timed press.
// Define KEYPAD_EMU_FIFO_EN for a 4-entry code queue; otherwise a single holding register is used.
module keypad_emulator #(
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 16
) (
    input  logic                clk,
    input  logic                rst,
    keypad_emulator_if.slave    key_if,
    input  logic [3:0]          keypadRow,
    output logic [3:0]          keypadCol,
    output logic                busy,
    output logic [2:0]          fifo_count
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PRESS = 2'd1, ST_GAP = 2'd2} state_t;

    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES - 1);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [3:0]  cur_key_q;
    logic [2:0]  count_q;
    logic [3:0]  head_s;
    logic        full_s;
    logic        empty_s;
    logic        push_s;
    logic        pop_s;
    logic [7:0]  map_s;

    // Inverse of the scanner decode: key code to {active-low row, active-low column}.
    function automatic logic [7:0] key_map(input logic [3:0] code);
        logic [7:0] rc;
        case (code)
            4'h7:    rc = {4'b1110, 4'b1110};
            4'h4:    rc = {4'b1110, 4'b1101};
            4'h1:    rc = {4'b1110, 4'b1011};
            4'h0:    rc = {4'b1110, 4'b0111};
            4'h8:    rc = {4'b1101, 4'b1110};
            4'h5:    rc = {4'b1101, 4'b1101};
            4'h2:    rc = {4'b1101, 4'b1011};
            4'hA:    rc = {4'b1101, 4'b0111};
            4'h9:    rc = {4'b1011, 4'b1110};
            4'h6:    rc = {4'b1011, 4'b1101};
            4'h3:    rc = {4'b1011, 4'b1011};
            4'hB:    rc = {4'b1011, 4'b0111};
            4'hC:    rc = {4'b0111, 4'b1110};
            4'hD:    rc = {4'b0111, 4'b1101};
            4'hE:    rc = {4'b0111, 4'b1011};
            4'hF:    rc = {4'b0111, 4'b0111};
            default: rc = 8'hFF;
        endcase
        return rc;
    endfunction

    assign push_s           = key_if.key_valid && !full_s;
    assign pop_s            = (state_q == ST_IDLE) && !empty_s;
    assign key_if.key_ready = !full_s;
    assign fifo_count       = count_q;
    assign busy             = (state_q != ST_IDLE) || (count_q != 3'd0);

`ifdef KEYPAD_EMU_FIFO_EN
    logic [3:0] mem_q [4];
    logic [1:0] wr_ptr_q;
    logic [1:0] rd_ptr_q;

    assign full_s  = (count_q == 3'd4);
    assign empty_s = (count_q == 3'd0);
    assign head_s  = mem_q[rd_ptr_q];

    // Circular code queue; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= 4'd0;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= key_if.key_code;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end
`else
    logic [3:0] hold_q;
    logic       hold_valid_q;

    assign full_s  = hold_valid_q;
    assign empty_s = !hold_valid_q;
    assign head_s  = hold_q;
    assign count_q = {2'b00, hold_valid_q};

    // Single holding register; push only when empty and pop only when full, so they never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q       <= 4'd0;
            hold_valid_q <= 1'b0;
        end else if (push_s) begin
            hold_q       <= key_if.key_code;
            hold_valid_q <= 1'b1;
        end else if (pop_s) begin
            hold_valid_q <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_q;
        end
    end
`endif

    // Press/gap sequencer: one key per HOLD+GAP+1 cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 16'd0;
            cur_key_q <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        cur_key_q <= head_s;
                        cnt_q     <= HOLD_LOAD;
                        state_q   <= ST_PRESS;
                    end
                end
                ST_PRESS: begin
                    if (cnt_q == 16'd0) begin
                        cnt_q   <= GAP_LOAD;
                        state_q <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == 16'd0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: begin
                    cnt_q   <= 16'd0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign map_s = key_map(cur_key_q);

    // Column return follows the row strobe with no register stage; malformed rows never match a key row.
    always_comb begin
        keypadCol = 4'b1111;
        if ((state_q == ST_PRESS) && (keypadRow == map_s[7:4])) begin
            keypadCol = map_s[3:0];
        end else begin
            keypadCol = 4'b1111;
        end
    end

endmodule
